icb_arbt: RTL and testbench
===========================

// Module: icb_arbt
// PURPOSE
//  N-to-1 ICB arbiter: merges ARBT_NUM initiator ICB ports onto one target ICB port.
//  Mirror of the 1-to-N split path; sits in front of a shared slave (e.g. ESC register file).
//  Grants one command per handshake and records the one-hot grant in a response-ID FIFO.
//  Responses are routed back to the port at the FIFO head, strictly in order.
// PARAMETERS
//  ARBT_NUM     4  number of initiator ports (>=2)
//  FIFO_DP      2  response-ID FIFO depth = max outstanding commands (>=1)
//  ARBT_SCHEME  1  0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clk                  in   1            clock
//  rst_n                in   1            async reset, active low
//  i_bus_icb_cmd_valid  in   ARBT_NUM     per-port command valid
//  i_bus_icb_cmd_ready  out  ARBT_NUM     per-port command ready
//  i_bus_icb_cmd_read   in   ARBT_NUM     per-port 1=read 0=write
//  i_bus_icb_cmd_addr   in   ARBT_NUM*16  per-port address, port k at [k*16+:16]
//  i_bus_icb_cmd_wdata  in   ARBT_NUM*8   per-port write data, port k at [k*8+:8]
//  i_bus_icb_rsp_valid  out  ARBT_NUM     per-port response valid
//  i_bus_icb_rsp_ready  in   ARBT_NUM     per-port response ready
//  i_bus_icb_rsp_err    out  ARBT_NUM     per-port response error
//  i_bus_icb_rsp_rdata  out  ARBT_NUM*8   per-port read data
//  o_icb_cmd_valid/ready/read  out/in/out  1   merged command handshake + read flag
//  o_icb_cmd_addr       out  16           merged address
//  o_icb_cmd_wdata      out  8            merged write data
//  o_icb_rsp_valid      in   1            target response valid
//  o_icb_rsp_ready      out  1            target response ready
//  o_icb_rsp_err        in   1            target response error
//  o_icb_rsp_rdata      in   8            target read data
// BEHAVIOUR
//  - One clock clk; reset rst_n is asynchronous, active low.
//  - Reset: FIFO empty, rr_ptr=0, lock=0 => o_icb_rsp_ready=0, all i_bus_icb_rsp_valid=0,
//    all i_bus_icb_cmd_ready=0 unless granted; no response is forwarded.
//  - Grant (comb, one-hot): scheme 0 lowest valid index; scheme 1 first valid index
//    searching from rr_ptr upward, wrapping ARBT_NUM-1 -> 0. No valid => grant=0.
//  - Lock: if o_icb_cmd_valid=1 and o_icb_cmd_ready=0, grant is registered and held
//    until handshake; later-arriving higher-priority requests do not preempt it.
//  - o_icb_cmd_valid = |(grant & valid) & fifo_wr_ok; read/addr/wdata muxed from granted port.
//  - i_bus_icb_cmd_ready[k] = grant[k] & o_icb_cmd_ready & fifo_wr_ok; ungranted ports see 0.
//  - cmd handshake: push grant into FIFO; rr_ptr <= granted index + 1 (mod ARBT_NUM).
//  - fifo_wr_ok = ~full | pop (push into full FIFO permitted only in cycle of a pop).
//  - Response: head = FIFO head one-hot (0 when empty). i_bus_icb_rsp_valid[k] =
//    head[k] & o_icb_rsp_valid; err/rdata broadcast to all ports (qualify by valid).
//  - o_icb_rsp_ready = ~empty & |(head & i_bus_icb_rsp_ready); pop on o_icb_rsp handshake.
//  - No zero-cycle response: response presented while FIFO empty stalls (ready=0).
//  - Simultaneous push+pop: count unchanged, pointers both advance, with wrap.
//  - Latency: combinational cmd path (0 cycles); response 0 cycles from target to port.
//  - Reset mid-transaction: outstanding IDs discarded; target must also be reset.
// STRUCTURE
//  - ICB_AW=16, ICB_DW=8 belong in the shared ICB defines header used by split and arbiter.
//  - One sub-module: sirv_gnrl_fifo (DP=FIFO_DP, DW=ARBT_NUM) for the response-ID FIFO
//    with count/empty/full; arbiter logic, lock and rr_ptr stay in this module.
// TESTING
//  - Reset then idle: all valids 0 -> all readies/valids 0, o_icb_rsp_ready=0.
//  - RR, ports 0..3 all valid, target ready, rsp 1 cycle later -> grants 0,1,2,3,0 in order.
//  - Scheme 0, ports 1,3 valid -> port 1 served every time until it drops; port 3 then.
//  - Port 2 valid, target ready=0 for 3 cycles, port 0 raises valid in cycle 1 -> grant
//    stays port 2; port 0 served next, addr 16'h0120/wdata 8'hA5 delivered unchanged.
//  - FIFO_DP=2, two cmds (port 1, then 3) no rsp -> third cmd blocked (ready=0); rsp err=1,
//    rdata 8'h5C -> only port 1 rsp_valid=1, err=1; then port 3; then third cmd accepted.
//  - Full FIFO + rsp pop and new cmd same cycle -> both accepted, count stays 2.

Source files
------------

// File: rtl/icb_arbt_pkg.sv
// Shared ICB bus widths and arbiter helpers for the N-to-1 ICB arbiter.
package icb_arbt_pkg;

    // ICB address and data widths, common to the split and arbiter paths.
    localparam int ICB_AW = 16;
    localparam int ICB_DW = 8;

    // Arbitration policy selected by the ARBT_SCHEME parameter.
    typedef enum int unsigned {
        ARB_FIXED = 0,  // lowest valid index wins
        ARB_RR    = 1   // first valid index at or after the round-robin pointer
    } arbt_scheme_e;

    // Index width that stays at least one bit wide, so a depth or port count of 1
    // still yields a legal vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sirv_gnrl_fifo.sv
// Response-ID FIFO: holds the one-hot grant of each accepted command until
// its response has been returned.
module sirv_gnrl_fifo
    import icb_arbt_pkg::*;
#(
    parameter int DP = 2,
    parameter int DW = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o,
    output logic [$clog2(DP+1)-1:0]  count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = clog2_min1(DP);
    localparam int CW = $clog2(DP + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DP - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DP);

    logic [DW-1:0] mem_q [DP];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wr_ptr_d = do_push ? ((wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? ((rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;

    always_comb begin
        // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and a latch is never inferred.
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; entries are only read while the count marks them live.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale contents are never observed because the consumer masks the head with empty.
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/icb_arbt.sv
// N-to-1 ICB arbiter: merges ARBT_NUM initiator ports onto one target port,
// records each grant in a response-ID FIFO and routes responses back in order.
module icb_arbt
    import icb_arbt_pkg::*;
#(
    parameter int ARBT_NUM    = 4,
    parameter int FIFO_DP     = 2,
    parameter int ARBT_SCHEME = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [ARBT_NUM-1:0]         i_bus_icb_cmd_valid,
    output logic [ARBT_NUM-1:0]         i_bus_icb_cmd_ready,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_cmd_read,
    input  logic [ARBT_NUM*ICB_AW-1:0]  i_bus_icb_cmd_addr,
    input  logic [ARBT_NUM*ICB_DW-1:0]  i_bus_icb_cmd_wdata,
    output logic [ARBT_NUM-1:0]         i_bus_icb_rsp_valid,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_rsp_ready,
    output logic [ARBT_NUM-1:0]         i_bus_icb_rsp_err,
    output logic [ARBT_NUM*ICB_DW-1:0]  i_bus_icb_rsp_rdata,

    output logic                        o_icb_cmd_valid,
    input  logic                        o_icb_cmd_ready,
    output logic                        o_icb_cmd_read,
    output logic [ICB_AW-1:0]           o_icb_cmd_addr,
    output logic [ICB_DW-1:0]           o_icb_cmd_wdata,
    input  logic                        o_icb_rsp_valid,
    output logic                        o_icb_rsp_ready,
    input  logic                        o_icb_rsp_err,
    input  logic [ICB_DW-1:0]           o_icb_rsp_rdata
);

    localparam int PW = clog2_min1(ARBT_NUM);
    localparam int CW = $clog2(FIFO_DP + 1);
    localparam logic [PW:0]   NUM_W    = (PW + 1)'(ARBT_NUM);
    localparam logic [PW-1:0] LAST_IDX = PW'(ARBT_NUM - 1);
    localparam logic [CW-1:0] DP_CNT   = CW'(FIFO_DP);

    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                lock_q, lock_d;
    logic [ARBT_NUM-1:0] lock_grant_q, lock_grant_d;

    logic [ARBT_NUM-1:0] arb_grant;
    logic [ARBT_NUM-1:0] grant;
    logic [PW-1:0]       grant_idx;
    logic [PW:0]         pos;
    logic                found;

    logic [ARBT_NUM-1:0] head;
    logic [ARBT_NUM-1:0] fifo_rdata;
    logic [CW-1:0]       fifo_cnt;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_wr_ok;
    logic                cmd_hsk;
    logic                rsp_hsk;

    // Fresh arbitration: fixed priority from index 0, or round-robin from rr_ptr with wrap.
    always_comb begin
        arb_grant = '0;
        found     = 1'b0;
        pos       = '0;
        for (int i = 0; i < ARBT_NUM; i++) begin
            if (ARBT_SCHEME == int'(ARB_RR)) begin
                pos = {1'b0, rr_ptr_q} + (PW + 1)'(i);
                if (pos >= NUM_W) begin
                    pos = pos - NUM_W;
                end
            end else begin
                pos = (PW + 1)'(i);
            end
            if (!found && i_bus_icb_cmd_valid[pos[PW-1:0]]) begin
                arb_grant[pos[PW-1:0]] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

    // A stalled command keeps its grant so a later, higher-priority request cannot preempt it.
    assign grant = lock_q ? lock_grant_q : arb_grant;

    // Merge the granted port's command fields and encode the grant as an index.
    always_comb begin
        o_icb_cmd_read  = 1'b0;
        o_icb_cmd_addr  = '0;
        o_icb_cmd_wdata = '0;
        grant_idx       = '0;
        for (int k = 0; k < ARBT_NUM; k++) begin
            o_icb_cmd_read  = o_icb_cmd_read | (grant[k] & i_bus_icb_cmd_read[k]);
            o_icb_cmd_addr  = o_icb_cmd_addr  | ({ICB_AW{grant[k]}} & i_bus_icb_cmd_addr[k*ICB_AW +: ICB_AW]);
            o_icb_cmd_wdata = o_icb_cmd_wdata | ({ICB_DW{grant[k]}} & i_bus_icb_cmd_wdata[k*ICB_DW +: ICB_DW]);
            grant_idx       = grant_idx | (grant[k] ? PW'(k) : '0);
        end
    end

    // Response side: head of the ID FIFO picks the single port that sees this response.
    assign head                = fifo_empty ? '0 : fifo_rdata;
    assign i_bus_icb_rsp_valid = head & {ARBT_NUM{o_icb_rsp_valid}};
    assign i_bus_icb_rsp_err   = {ARBT_NUM{o_icb_rsp_err}};
    assign i_bus_icb_rsp_rdata = {ARBT_NUM{o_icb_rsp_rdata}};
    assign o_icb_rsp_ready     = ~fifo_empty & (|(head & i_bus_icb_rsp_ready));
    assign rsp_hsk             = o_icb_rsp_valid & o_icb_rsp_ready;

    // Command side: a new command needs a free ID slot, or one being freed this cycle.
    assign fifo_wr_ok          = ~fifo_full | rsp_hsk;
    assign o_icb_cmd_valid     = (|(grant & i_bus_icb_cmd_valid)) & fifo_wr_ok;
    assign i_bus_icb_cmd_ready = grant & {ARBT_NUM{o_icb_cmd_ready & fifo_wr_ok}};
    assign cmd_hsk             = o_icb_cmd_valid & o_icb_cmd_ready;

    // Next round-robin pointer and lock state.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (cmd_hsk) begin
            rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PW'(1);
        end
        lock_d       = o_icb_cmd_valid & ~o_icb_cmd_ready;
        lock_grant_d = lock_d ? grant : '0;
    end

    // Round-robin pointer and grant lock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_grant_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_grant_q <= lock_grant_d;
        end
    end

    sirv_gnrl_fifo #(
        .DP (FIFO_DP),
        .DW (ARBT_NUM)
    ) u_rsp_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_hsk),
        .pop_i   (rsp_hsk),
        .wdata_i (grant),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Occupancy never exceeds the depth and the full flag agrees with the count.
    assert property (@(posedge clk) disable iff (!rst_n)
        (fifo_cnt <= DP_CNT) && (fifo_full == (fifo_cnt == DP_CNT)));

endmodule

// File: tb/tb_icb_arbt.sv
// Bench for icb_arbt: a round-robin and a fixed-priority instance share one
// stimulus set (sel picks the active one); scoreboard queues hold expected
// commands and responses, popped by negedge monitors on each target handshake.
module tb_icb_arbt;

    typedef struct packed {
        logic [3:0]  port;
        logic        read;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cmd_exp_t;

    typedef struct packed {
        logic [3:0]  port;
        logic        err;
        logic [7:0]  rdata;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sel;

    logic [3:0]  cmd_valid, cmd_read, rsp_ready;
    logic [63:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        t_cmd_ready, t_rsp_valid, t_rsp_err;
    logic [7:0]  t_rsp_rdata;

    logic [3:0]  rr_cmd_ready, rr_rsp_valid, rr_rsp_err;
    logic [31:0] rr_rsp_rdata;
    logic        rr_o_valid, rr_o_read, rr_o_rsp_ready;
    logic [15:0] rr_o_addr;
    logic [7:0]  rr_o_wdata;

    logic [3:0]  fp_cmd_ready, fp_rsp_valid, fp_rsp_err;
    logic [31:0] fp_rsp_rdata;
    logic        fp_o_valid, fp_o_read, fp_o_rsp_ready;
    logic [15:0] fp_o_addr;
    logic [7:0]  fp_o_wdata;

    logic [3:0]  cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        o_valid, o_read, o_rsp_ready;
    logic [15:0] o_addr;
    logic [7:0]  o_wdata;

    int n_total = 0;
    int n_bad   = 0;
    cmd_exp_t cmd_q[$];
    rsp_exp_t rsp_q[$];

    logic [15:0] tbl_addr  [4] = '{16'h0120, 16'h1111, 16'h2222, 16'h3333};
    logic [7:0]  tbl_wdata [4] = '{8'hA5, 8'h11, 8'h22, 8'h33};
    logic [3:0]  tbl_read      = 4'b0110;

    always #5 clk = ~clk;

    icb_arbt #(.ARBT_NUM(4), .FIFO_DP(2), .ARBT_SCHEME(1)) dut_rr (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_bus_icb_cmd_valid (cmd_valid & {4{~sel}}),
        .i_bus_icb_cmd_ready (rr_cmd_ready),
        .i_bus_icb_cmd_read  (cmd_read),
        .i_bus_icb_cmd_addr  (cmd_addr),
        .i_bus_icb_cmd_wdata (cmd_wdata),
        .i_bus_icb_rsp_valid (rr_rsp_valid),
        .i_bus_icb_rsp_ready (rsp_ready),
        .i_bus_icb_rsp_err   (rr_rsp_err),
        .i_bus_icb_rsp_rdata (rr_rsp_rdata),
        .o_icb_cmd_valid     (rr_o_valid),
        .o_icb_cmd_ready     (t_cmd_ready & ~sel),
        .o_icb_cmd_read      (rr_o_read),
        .o_icb_cmd_addr      (rr_o_addr),
        .o_icb_cmd_wdata     (rr_o_wdata),
        .o_icb_rsp_valid     (t_rsp_valid & ~sel),
        .o_icb_rsp_ready     (rr_o_rsp_ready),
        .o_icb_rsp_err       (t_rsp_err),
        .o_icb_rsp_rdata     (t_rsp_rdata)
    );

    icb_arbt #(.ARBT_NUM(4), .FIFO_DP(2), .ARBT_SCHEME(0)) dut_fp (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_bus_icb_cmd_valid (cmd_valid & {4{sel}}),
        .i_bus_icb_cmd_ready (fp_cmd_ready),
        .i_bus_icb_cmd_read  (cmd_read),
        .i_bus_icb_cmd_addr  (cmd_addr),
        .i_bus_icb_cmd_wdata (cmd_wdata),
        .i_bus_icb_rsp_valid (fp_rsp_valid),
        .i_bus_icb_rsp_ready (rsp_ready),
        .i_bus_icb_rsp_err   (fp_rsp_err),
        .i_bus_icb_rsp_rdata (fp_rsp_rdata),
        .o_icb_cmd_valid     (fp_o_valid),
        .o_icb_cmd_ready     (t_cmd_ready & sel),
        .o_icb_cmd_read      (fp_o_read),
        .o_icb_cmd_addr      (fp_o_addr),
        .o_icb_cmd_wdata     (fp_o_wdata),
        .o_icb_rsp_valid     (t_rsp_valid & sel),
        .o_icb_rsp_ready     (fp_o_rsp_ready),
        .o_icb_rsp_err       (t_rsp_err),
        .o_icb_rsp_rdata     (t_rsp_rdata)
    );

    assign cmd_ready   = sel ? fp_cmd_ready   : rr_cmd_ready;
    assign rsp_valid   = sel ? fp_rsp_valid   : rr_rsp_valid;
    assign rsp_err     = sel ? fp_rsp_err     : rr_rsp_err;
    assign rsp_rdata   = sel ? fp_rsp_rdata   : rr_rsp_rdata;
    assign o_valid     = sel ? fp_o_valid     : rr_o_valid;
    assign o_read      = sel ? fp_o_read      : rr_o_read;
    assign o_addr      = sel ? fp_o_addr      : rr_o_addr;
    assign o_wdata     = sel ? fp_o_wdata     : rr_o_wdata;
    assign o_rsp_ready = sel ? fp_o_rsp_ready : rr_o_rsp_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cmd(input int k);
        cmd_exp_t e;
        e.port  = 4'b0001 << k;
        e.read  = tbl_read[k];
        e.addr  = tbl_addr[k];
        e.wdata = tbl_wdata[k];
        cmd_q.push_back(e);
    endtask

    task automatic rsp_drive(input int k, input logic err, input logic [7:0] d);
        rsp_exp_t e;
        t_rsp_valid = 1'b1;
        t_rsp_err   = err;
        t_rsp_rdata = d;
        e.port  = 4'b0001 << k;
        e.err   = err;
        e.rdata = d;
        rsp_q.push_back(e);
    endtask

    task automatic rsp_idle();
        t_rsp_valid = 1'b0;
        t_rsp_err   = 1'b0;
        t_rsp_rdata = 8'h00;
    endtask

    // Command monitor: every target-side command handshake must match the queue head.
    always @(negedge clk) begin
        cmd_exp_t e;
        if (rst_n === 1'b1 && o_valid === 1'b1 && t_cmd_ready === 1'b1) begin
            if (cmd_q.size() == 0) begin
                check("cmd_unexpected", 32'(cmd_ready), 32'h0);
            end else begin
                e = cmd_q.pop_front();
                check("cmd_grant", 32'(cmd_ready), 32'(e.port));
                check("cmd_read",  32'(o_read),    32'(e.read));
                check("cmd_addr",  32'(o_addr),    32'(e.addr));
                check("cmd_wdata", 32'(o_wdata),   32'(e.wdata));
            end
        end
    end

    // Response monitor: every target-side response handshake must match the queue head.
    always @(negedge clk) begin
        rsp_exp_t e;
        if (rst_n === 1'b1 && t_rsp_valid === 1'b1 && o_rsp_ready === 1'b1) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e = rsp_q.pop_front();
                check("rsp_port",  32'(rsp_valid), 32'(e.port));
                check("rsp_err",   32'(rsp_err),   32'({4{e.err}}));
                check("rsp_rdata", rsp_rdata,      {4{e.rdata}});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        sel         = 1'b0;
        rst_n       = 1'b0;
        cmd_valid   = 4'h0;
        cmd_read    = tbl_read;
        rsp_ready   = 4'hF;
        t_cmd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cmd_addr[k*16 +: 16] = tbl_addr[k];
            cmd_wdata[k*8 +: 8]  = tbl_wdata[k];
        end
        rsp_idle();

        // Reset state.
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready),   32'h0);
        check("rst_cmd_valid", 32'(o_valid),     32'h0);
        check("rst_rsp_valid", 32'(rsp_valid),   32'h0);
        check("rst_rsp_ready", 32'(o_rsp_ready), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Idle with a response presented to an empty FIFO: nothing forwarded.
        t_rsp_valid = 1'b1;
        t_rsp_rdata = 8'hEE;
        @(negedge clk);
        check("idle_rsp_ready", 32'(o_rsp_ready), 32'h0);
        check("idle_rsp_valid", 32'(rsp_valid),   32'h0);
        check("idle_cmd_ready", 32'(cmd_ready),   32'h0);
        step();
        rsp_idle();

        // Round-robin, all ports valid: grants 0,1,2,3,0, responses one cycle later.
        cmd_valid   = 4'hF;
        t_cmd_ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_cmd(i % 4);
        @(negedge clk);
        step();
        for (int i = 1; i <= 4; i++) begin
            rsp_drive(i - 1, 1'b0, 8'(8'hC0 + i));
            @(negedge clk);
            step();
        end
        cmd_valid   = 4'h0;
        t_cmd_ready = 1'b0;
        rsp_drive(0, 1'b0, 8'hC5);
        @(negedge clk);
        step();
        rsp_idle();
        @(negedge clk);
        step();

        // Fixed priority, ports 1 and 3 valid: port 1 wins until it drops.
        sel         = 1'b1;
        cmd_valid   = 4'b1010;
        t_cmd_ready = 1'b1;
        exp_cmd(1); exp_cmd(1); exp_cmd(1); exp_cmd(3);
        @(negedge clk);
        step();
        rsp_drive(1, 1'b0, 8'h41);
        @(negedge clk);
        step();
        rsp_drive(1, 1'b0, 8'h42);
        @(negedge clk);
        step();
        cmd_valid = 4'b1000;
        rsp_drive(1, 1'b0, 8'h43);
        @(negedge clk);
        step();
        cmd_valid   = 4'h0;
        t_cmd_ready = 1'b0;
        rsp_drive(3, 1'b0, 8'h44);
        @(negedge clk);
        step();
        rsp_idle();
        @(negedge clk);
        step();

        // Lock on the fixed-priority instance: stalled port 2 is not preempted by port 0.
        cmd_valid = 4'b0100;
        @(negedge clk);
        check("lock_c0_valid", 32'(o_valid),   32'h1);
        check("lock_c0_addr",  32'(o_addr),    32'h2222);
        check("lock_c0_ready", 32'(cmd_ready), 32'h0);
        step();
        cmd_valid = 4'b0101;
        @(negedge clk);
        check("lock_c1_addr",  32'(o_addr),  32'h2222);
        check("lock_c1_wdata", 32'(o_wdata), 32'h22);
        step();
        @(negedge clk);
        check("lock_c2_addr", 32'(o_addr), 32'h2222);
        step();
        t_cmd_ready = 1'b1;
        exp_cmd(2);
        @(negedge clk);
        check("lock_c3_ready", 32'(cmd_ready), 32'b0100);
        step();
        cmd_valid = 4'b0001;
        exp_cmd(0);
        @(negedge clk);
        check("lock_p0_addr",  32'(o_addr),  32'h0120);
        check("lock_p0_wdata", 32'(o_wdata), 32'hA5);
        step();
        cmd_valid   = 4'h0;
        t_cmd_ready = 1'b0;
        rsp_drive(2, 1'b0, 8'h12);
        @(negedge clk);
        step();
        rsp_drive(0, 1'b1, 8'h34);
        @(negedge clk);
        step();
        rsp_idle();
        @(negedge clk);
        step();

        // FIFO full on the round-robin instance: third command blocked, in-order responses.
        sel         = 1'b0;
        cmd_valid   = 4'b0010;
        t_cmd_ready = 1'b1;
        exp_cmd(1);
        @(negedge clk);
        step();
        cmd_valid = 4'b1000;
        exp_cmd(3);
        @(negedge clk);
        step();
        cmd_valid = 4'b0001;
        @(negedge clk);
        check("full_blk_valid", 32'(o_valid),   32'h0);
        check("full_blk_ready", 32'(cmd_ready), 32'h0);
        step();
        cmd_valid   = 4'h0;
        t_rsp_valid = 1'b1;
        t_rsp_err   = 1'b1;
        t_rsp_rdata = 8'h5C;
        rsp_ready   = 4'b1101;
        @(negedge clk);
        check("hold_rsp_valid", 32'(rsp_valid),   32'b0010);
        check("hold_rsp_ready", 32'(o_rsp_ready), 32'h0);
        check("hold_rsp_err",   32'(rsp_err),     32'hF);
        step();
        rsp_ready = 4'hF;
        rsp_drive(1, 1'b1, 8'h5C);
        @(negedge clk);
        step();
        rsp_drive(3, 1'b0, 8'h3D);
        @(negedge clk);
        step();
        rsp_idle();
        cmd_valid = 4'b0001;
        exp_cmd(0);
        @(negedge clk);
        step();
        cmd_valid = 4'b0010;
        exp_cmd(1);
        @(negedge clk);
        step();

        // Full FIFO with a pop and a new command in the same cycle: both accepted.
        cmd_valid = 4'b0100;
        exp_cmd(2);
        rsp_drive(0, 1'b0, 8'h77);
        @(negedge clk);
        check("swap_cmd_ready", 32'(cmd_ready),   32'b0100);
        check("swap_rsp_ready", 32'(o_rsp_ready), 32'h1);
        step();
        rsp_idle();
        cmd_valid = 4'b1000;
        @(negedge clk);
        check("swap_full_valid", 32'(o_valid),   32'h0);
        check("swap_full_ready", 32'(cmd_ready), 32'h0);
        step();
        cmd_valid   = 4'h0;
        t_cmd_ready = 1'b0;
        rsp_drive(1, 1'b0, 8'h88);
        @(negedge clk);
        step();
        rsp_drive(2, 1'b0, 8'h99);
        @(negedge clk);
        step();
        t_rsp_valid = 1'b1;
        t_rsp_rdata = 8'hEE;
        @(negedge clk);
        check("drain_rsp_ready", 32'(o_rsp_ready), 32'h0);
        check("drain_rsp_valid", 32'(rsp_valid),   32'h0);
        step();
        rsp_idle();
        @(negedge clk);

        check("cmd_q_left", 32'(cmd_q.size()), 32'h0);
        check("rsp_q_left", 32'(rsp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
